cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Round-robin arbiter and output register for the Common Data Bus (CDB).
//   Functional units (LU, adders, multipliers, load buffers) request the bus
//   with a result tag/data pair. One winner per cycle is selected through the
//   mux_N_1 tree and registered onto the CDB for reservation stations and the
//   register status table. A downstream stall freezes the bus.
// PARAMETERS
//   NUM_SRC   4    number of requesting functional units; power of 2, 2..16
//   DATA_W    32   result data width
//   TAG_W     4    reservation-station tag width; tag 0 = "no producer"
//   SEL_W     2    log2(NUM_SRC); must match NUM_SRC
// PORTS
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous active-high reset
//   req        in   NUM_SRC         per-source broadcast request
//   tag_in     in   NUM_SRC*TAG_W   source i tag at [i*TAG_W +: TAG_W]
//   data_in    in   NUM_SRC*DATA_W  source i data at [i*DATA_W +: DATA_W]
//   cdb_stall  in   1               consumer cannot accept a new broadcast
//   grant      out  NUM_SRC         one-hot; source i's request accepted this cycle
//   cdb_valid  out  1               CDB holds a valid broadcast
//   cdb_tag    out  TAG_W           broadcast tag
//   cdb_data   out  DATA_W          broadcast data
// BEHAVIOUR
//   - Reset (async, any time): cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0;
//     grant forced 0 while rst high. In-flight broadcast discarded; sources
//     keep req high and are re-arbitrated from rr_ptr=0 after release.
//   - accept = ~cdb_valid | ~cdb_stall. grant is combinational, 0 if !accept.
//   - Winner: first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... modulo
//     NUM_SRC (wrap-around). At most one grant bit set; none if req==0.
//   - Source handshake: source holds req/tag_in/data_in stable until it sees
//     grant[i]=1 in a cycle; deasserts or presents next result next cycle.
//   - Edge with accept & |grant: cdb_valid<=1, cdb_tag/cdb_data <= winner's
//     tag/data (selected by winner index), rr_ptr <= (winner+1) mod NUM_SRC.
//   - Edge with accept & no request: cdb_valid<=0, tag/data hold, rr_ptr holds.
//   - Edge with !accept (valid & stall): all registers hold.
//   - Latency: grant cycle N -> on CDB from edge ending cycle N; one broadcast
//     per cycle max, back-to-back with no bubble when stall low.
//   - A request with tag_in==0 is a source bug; broadcast anyway, flag in sim.
//   - Fairness: any continuously requesting source granted within NUM_SRC
//     accept cycles.
// TESTING
//   1 rst high mid-broadcast (cdb_valid=1) -> outputs 0 immediately, async;
//     after release req=4'b0110 -> grant=0010, rr_ptr=2.
//   2 req=4'b1111 held, stall=0, 8 cycles -> grants 0001,0010,0100,1000,
//     0001,... ; cdb_tag follows tag_in[0..3] one cycle later, no bubbles.
//   3 rr_ptr=3, req=4'b0101 -> grant=0001 (wrap), next rr_ptr=1.
//   4 cdb_valid=1 tag=5 data=0xDEADBEEF, stall=1 for 3 cycles, req=4'b0010
//     -> grant=0 and CDB frozen; stall drop -> grant=0010, new data next edge.
//   5 req=0, stall=0 after a broadcast -> cdb_valid=0 next edge, tag/data hold.
//   6 random req/stall, 10k cycles -> grant one-hot-or-zero, no source waits
//     >4 accept cycles, scoreboard matches every granted tag/data on CDB.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter and output register for the Common Data Bus.
//   Functional units request the bus with a tag/data pair. Each cycle one
//   winner is chosen, starting the scan at rr_ptr and wrapping around. The
//   winner's result is registered onto the CDB. A downstream stall freezes
//   a valid broadcast, and no new grant is issued while it is frozen.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-source broadcast request
//   tag_in     source i tag at [i*TAG_W +: TAG_W]
//   data_in    source i data at [i*DATA_W +: DATA_W]
//   cdb_stall  consumer cannot accept a new broadcast
//   grant      one-hot accept of a source's request this cycle (combinational)
//   cdb_valid  CDB holds a valid broadcast
//   cdb_tag    broadcast tag
//   cdb_data   broadcast data
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int SEL_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*TAG_W-1:0]  tag_in,
  input  logic [NUM_SRC*DATA_W-1:0] data_in,
  input  logic                      cdb_stall,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  win_idx;
  logic [SEL_W-1:0]  scan_idx;
  logic              found;
  logic              accept;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // The bus can take a new broadcast when it is empty or the consumer is
  // not stalling.
  assign accept = ~cdb_valid | ~cdb_stall;

  // Scan from rr_ptr upwards. NUM_SRC is a power of two, so the SEL_W-bit
  // add wraps modulo NUM_SRC for free.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = rr_ptr + SEL_W'(k);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // N:1 result mux steered by the winner index.
  assign win_tag  = tag_in[win_idx*TAG_W +: TAG_W];
  assign win_data = data_in[win_idx*DATA_W +: DATA_W];

  // Grant is suppressed while reset is held so that no source retires a
  // result that the reset is about to discard.
  always_comb begin
    grant = '0;
    if (!rst && accept && found) begin
      grant[win_idx] = 1'b1;
    end
  end

  // CDB register and round-robin pointer. If there is no request, the bus
  // goes idle but keeps the last tag/data. A stalled valid broadcast holds
  // everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      if (found) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= win_tag;
        cdb_data  <= win_data;
        rr_ptr    <= win_idx + SEL_W'(1);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Testbench for cdb_arbiter. A behavioural model keeps the round-robin
//   pointer as a plain integer and the bus contents as variables. The model
//   is checked against the DUT on every falling edge. Directed sequences
//   pin the model with literal values. A random phase follows the
//   request/grant handshake.
module tb_cdb_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int SEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*TAG_W-1:0]  tag_in;
  logic [NUM_SRC*DATA_W-1:0] data_in;
  logic                      cdb_stall;
  logic [NUM_SRC-1:0]        grant;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  cdb_arbiter #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .SEL_W   (SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tag_in    (tag_in),
    .data_in   (data_in),
    .cdb_stall (cdb_stall),
    .grant     (grant),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  always #5 clk = ~clk;

  // Model state: pointer, bus contents and the grant issued at the last edge.
  int                 m_ptr   = 0;
  bit                 m_valid = 1'b0;
  logic [TAG_W-1:0]   m_tag   = '0;
  logic [DATA_W-1:0]  m_data  = '0;
  logic [NUM_SRC-1:0] last_grant = '0;
  int                 wait_cnt [NUM_SRC];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] r, input logic s);
    req       = r;
    cdb_stall = s;
  endtask

  task automatic set_src(input int i, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    tag_in[i*TAG_W +: TAG_W]    = t;
    data_in[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_winner();
    int i;
    if (rst) return -1;
    if (m_valid && cdb_stall) return -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      i = (m_ptr + k) % NUM_SRC;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_SRC-1:0] model_grant();
    int w;
    w = model_winner();
    if (w < 0) return '0;
    return NUM_SRC'(1) << w;
  endfunction

  // Model update at each rising edge and on asynchronous reset.
  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_ptr      = 0;
      m_valid    = 1'b0;
      m_tag      = '0;
      m_data     = '0;
      last_grant = '0;
    end else begin
      w          = model_winner();
      last_grant = model_grant();
      if (!(m_valid && cdb_stall)) begin
        if (w >= 0) begin
          m_valid = 1'b1;
          m_tag   = tag_in[w*TAG_W +: TAG_W];
          m_data  = data_in[w*DATA_W +: DATA_W];
          m_ptr   = (w + 1) % NUM_SRC;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus one-hot and fairness bounds.
  always @(negedge clk) begin
    int worst;
    checkOutput("grant", 32'(grant), 32'(model_grant()));
    checkOutput("cdb_valid", 32'(cdb_valid), 32'(m_valid));
    checkOutput("cdb_tag", 32'(cdb_tag), 32'(m_tag));
    checkOutput("cdb_data", cdb_data, m_data);
    checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    worst = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst || !req[i] || grant[i]) wait_cnt[i] = 0;
      else if (!(m_valid && cdb_stall)) wait_cnt[i]++;
      if (wait_cnt[i] > worst) worst = wait_cnt[i];
    end
    n_cmp++;
    if (worst > NUM_SRC - 1) begin
      n_fail++;
      $display("[TB] FAIL fairness: waited %0d accept cycles, limit %0d at %0t",
               worst, NUM_SRC - 1, $time);
    end
  end

  logic [NUM_SRC-1:0] pending;

  initial begin
    for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] = 0;
    rst       = 1'b1;
    tag_in    = '0;
    data_in   = '0;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, TAG_W'(i + 1), 32'h100 + i);
    applyStimulus(4'b1111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(cdb_valid), 32'd0);
    checkOutput("rst_tag", 32'(cdb_tag), 32'd0);
    checkOutput("rst_data", cdb_data, 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    #1;

    // All four request continuously: strict rotation, no bubbles.
    for (int c = 0; c < 8; c++) begin
      checkOutput("rr_grant", 32'(grant), 32'(4'b0001 << (c % 4)));
      if (c > 0) begin
        checkOutput("rr_tag", 32'(cdb_tag), 32'((c - 1) % 4 + 1));
        checkOutput("rr_valid", 32'(cdb_valid), 32'd1);
      end
      step();
      #1;
    end
    checkOutput("rr_last_tag", 32'(cdb_tag), 32'd4);

    // No requests: bus goes idle, tag/data hold.
    applyStimulus(4'b0000, 1'b0);
    #1;
    checkOutput("idle_grant", 32'(grant), 32'd0);
    step();
    #1;
    checkOutput("idle_valid", 32'(cdb_valid), 32'd0);
    checkOutput("idle_tag", 32'(cdb_tag), 32'd4);
    checkOutput("idle_data", cdb_data, 32'h103);

    // Move pointer to 3, then check the wrap to source 0.
    applyStimulus(4'b0100, 1'b0);
    #1;
    checkOutput("ptr3_grant", 32'(grant), 32'b0100);
    step();
    applyStimulus(4'b0101, 1'b0);
    #1;
    checkOutput("wrap_grant", 32'(grant), 32'b0001);
    step();
    #1;
    checkOutput("wrap_tag", 32'(cdb_tag), 32'd1);
    checkOutput("ptr1_grant", 32'(grant), 32'b0100);
    step();

    // Stall freezes a valid broadcast and withholds grants.
    set_src(1, 4'd5, 32'hDEADBEEF);
    applyStimulus(4'b0010, 1'b0);
    #1;
    checkOutput("pre_stall_grant", 32'(grant), 32'b0010);
    step();
    set_src(1, 4'd6, 32'h12345678);
    applyStimulus(4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall_grant", 32'(grant), 32'd0);
      checkOutput("stall_tag", 32'(cdb_tag), 32'd5);
      checkOutput("stall_data", cdb_data, 32'hDEADBEEF);
      checkOutput("stall_valid", 32'(cdb_valid), 32'd1);
      step();
    end
    applyStimulus(4'b0010, 1'b0);
    #1;
    checkOutput("unstall_grant", 32'(grant), 32'b0010);
    step();
    #1;
    checkOutput("unstall_tag", 32'(cdb_tag), 32'd6);
    checkOutput("unstall_data", cdb_data, 32'h12345678);

    // Asynchronous reset in the middle of a valid broadcast.
    set_src(1, 4'd7, 32'h7777);
    set_src(2, 4'd8, 32'h8888);
    applyStimulus(4'b0110, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("async_valid", 32'(cdb_valid), 32'd0);
    checkOutput("async_tag", 32'(cdb_tag), 32'd0);
    checkOutput("async_data", cdb_data, 32'd0);
    checkOutput("async_grant", 32'(grant), 32'd0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_grant", 32'(grant), 32'b0010);
    step();
    #1;
    checkOutput("post_rst_tag", 32'(cdb_tag), 32'd7);
    checkOutput("post_rst_ptr2", 32'(grant), 32'b0100);

    // Random phase: sources follow the hold-until-granted handshake.
    pending = req;
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int i = 0; i < NUM_SRC; i++) begin
        if (last_grant[i]) pending[i] = 1'b0;
        if (!pending[i] && $urandom_range(0, 2) != 0) begin
          set_src(i, TAG_W'($urandom_range(1, 15)), $urandom);
          pending[i] = 1'b1;
        end
      end
      applyStimulus(pending, $urandom_range(0, 3) == 0);
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
